// File: rtl/jtpopeye_txt_arb.sv
// jtpopeye_txt_arb
// Shares the text-layer tile RAMs (code plane and colour plane) between
// CPU writes and the video scan. Every 8-pixel character cell reserves one
// slot for the scan fetch. All other slots are free for queued CPU writes,
// and so is every slot during blanking. CPU writes go through a small FIFO,
// so the CPU is held off only while that FIFO is full.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   pxl_cen        pixel clock enable; RAM-side outputs change only on these edges
//   H              horizontal pixel counter low bits (slot index within a cell)
//   blank          1 during horizontal or vertical blanking
//   scan_addr      tile address {V[7:3],H[7:3]} for the current scan fetch
//   cpu_we         CPU write request, sampled on every clk edge
//   cpu_addr       decoded CPU address: [11:10] 00 code, 01 colour, 1x ignored
//   cpu_din        CPU write data
//   cpu_wait       write queue full
//   ram_addr       address shared by both tile RAMs
//   ram_din        write data for the tile RAMs
//   code_we        code-plane write enable, one pxl_cen period wide
//   col_we         colour-plane write enable, one pxl_cen period wide
//   fetch          high for the pxl_cen period in which ram_addr is a scan address
//   ovf            sticky flag, set when a CPU write is dropped on a full queue
module jtpopeye_txt_arb #(
    parameter int         FIFO_AW    = 2,
    parameter logic [2:0] FETCH_SLOT = 3'd5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pxl_cen,
    input  logic [2:0]  H,
    input  logic        blank,
    input  logic [9:0]  scan_addr,
    input  logic        cpu_we,
    input  logic [11:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic        cpu_wait,
    output logic [9:0]  ram_addr,
    output logic [7:0]  ram_din,
    output logic        code_we,
    output logic        col_we,
    output logic        fetch,
    output logic        ovf
);

    localparam int               DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = 1;

    // Queue entry layout: [18] plane select, [17:8] tile address, [7:0] data
    logic [18:0]      mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic [18:0]      head;
    logic             full;
    logic             empty;
    logic             cpu_req;
    logic             push;
    logic             fetch_slot;
    logic             pop;

    // The pointers carry one extra wrap bit, so a full queue and an empty
    // queue can be told apart even though both have equal index bits.
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign cpu_wait = full;

    // Fullness is taken before any pop on the same edge, so a slot freed by a
    // pop on that edge is not available to a push on that same edge.
    assign cpu_req    = cpu_we && !cpu_addr[11];
    assign push       = cpu_req && !full;
    assign fetch_slot = !blank && (H == FETCH_SLOT);
    assign pop        = pxl_cen && !fetch_slot && !empty;
    assign head       = mem[rd_ptr[FIFO_AW-1:0]];

    // Write side of the queue, plus the sticky overflow flag for writes that
    // arrive while the queue is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            ovf    <= 1'b0;
        end else if (cpu_req) begin
            if (full) begin
                ovf <= 1'b1;
            end else begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
        end
    end

    // Queue storage does not need a reset. After reset the pointers mark the
    // queue empty, so stale contents are never issued.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= {cpu_addr[10:0], cpu_din};
        end
    end

    // Read side of the queue: it advances only when a write slot actually
    // issues an entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Slot decision on each pixel enable. The fetch slot always wins and
    // leaves the queue untouched. Any other slot issues the queue head, or
    // parks the read port on the scan address when there is nothing to write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr <= '0;
            ram_din  <= '0;
            code_we  <= 1'b0;
            col_we   <= 1'b0;
            fetch    <= 1'b0;
        end else if (pxl_cen) begin
            if (fetch_slot) begin
                ram_addr <= scan_addr;
                fetch    <= 1'b1;
                code_we  <= 1'b0;
                col_we   <= 1'b0;
            end else if (!empty) begin
                ram_addr <= head[17:8];
                ram_din  <= head[7:0];
                code_we  <= !head[18];
                col_we   <= head[18];
                fetch    <= 1'b0;
            end else begin
                ram_addr <= scan_addr;
                code_we  <= 1'b0;
                col_we   <= 1'b0;
                fetch    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtpopeye_txt_arb.sv
// Testbench for jtpopeye_txt_arb.
// The directed stimulus pushes each expected tile-RAM write into a
// scoreboard queue. A monitor checks the DUT after every pixel-enable edge
// and pops the queue whenever a write enable is seen. Static values such as
// fetch, cpu_wait, ovf and the idle address are checked directly.
module tb_jtpopeye_txt_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        pxl_cen;
    logic [2:0]  H;
    logic        blank;
    logic [9:0]  scan_addr;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_wait;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_din;
    logic        code_we;
    logic        col_we;
    logic        fetch;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    // Expected write: {ram_addr, ram_din, code_we, col_we, fetch}
    logic [20:0] exp_q[$];
    logic        cen_q = 1'b0;

    jtpopeye_txt_arb dut (
        .clk       (clk),
        .rst       (rst),
        .pxl_cen   (pxl_cen),
        .H         (H),
        .blank     (blank),
        .scan_addr (scan_addr),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_wait  (cpu_wait),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .code_we   (code_we),
        .col_we    (col_we),
        .fetch     (fetch),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Remember whether the last rising edge was a pixel-enable edge, so the
    // monitor looks at each new output state exactly once.
    always @(posedge clk) cen_q <= pxl_cen;

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && cen_q && (code_we || col_we)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got addr=%h din=%h code_we=%b col_we=%b, required no write",
                         ram_addr, ram_din, code_we, col_we);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                if ({ram_addr, ram_din, code_we, col_we, fetch} !== e) begin
                    errors++;
                    $display("[TB] FAIL write_issue: got addr=%h din=%h code=%b col=%b fetch=%b, required addr=%h din=%h code=%b col=%b fetch=%b",
                             ram_addr, ram_din, code_we, col_we, fetch,
                             e[20:11], e[10:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    // Drive one clock edge of stimulus, then return at the following
    // falling edge with the outputs settled.
    task automatic applyStimulus(input logic cen, input logic [2:0] h, input logic blk,
                                 input logic we, input logic [11:0] addr, input logic [7:0] din);
        pxl_cen  = cen;
        H        = h;
        blank    = blk;
        cpu_we   = we;
        cpu_addr = addr;
        cpu_din  = din;
        @(posedge clk);
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    task automatic expectWrite(input logic [9:0] addr, input logic [7:0] din, input logic colour);
        exp_q.push_back({addr, din, !colour, colour, 1'b0});
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    initial begin
        rst       = 1'b1;
        pxl_cen   = 1'b0;
        H         = 3'd0;
        blank     = 1'b0;
        scan_addr = 10'h2A5;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_din   = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", {ram_addr, ram_din, code_we, col_we, fetch, ovf, cpu_wait}, '0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single write in active video");
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b1, 12'h045, 8'hA7);
        expectWrite(10'h045, 8'hA7, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 12'h000, 8'h00);
        checkOutput("single_code_we", {code_we, col_we}, 2'b10);
        applyStimulus(1'b1, 3'd3, 1'b0, 1'b0, 12'h000, 8'h00);
        checkOutput("idle_scan_addr", {ram_addr, code_we, col_we, fetch}, {10'h2A5, 3'b000});
        checkOutput("idle_din_held", ram_din, 8'hA7);

        $display("[TB] push and pop on an empty queue in the same edge");
        applyStimulus(1'b1, 3'd1, 1'b0, 1'b1, 12'h523, 8'h5C);
        expectWrite(10'h123, 8'h5C, 1'b1);
        checkOutput("same_edge_empty_idle", {code_we, col_we}, 2'b00);
        applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 12'h000, 8'h00);

        $display("[TB] write colliding with the fetch slot");
        scan_addr = 10'h1C3;
        applyStimulus(1'b0, 3'd4, 1'b0, 1'b1, 12'h7FF, 8'h3C);
        expectWrite(10'h3FF, 8'h3C, 1'b1);
        applyStimulus(1'b1, 3'd5, 1'b0, 1'b0, 12'h000, 8'h00);
        checkOutput("fetch_slot", {fetch, code_we, col_we, ram_addr}, {3'b100, 10'h1C3});
        applyStimulus(1'b0, 3'd5, 1'b0, 1'b0, 12'h000, 8'h00);
        checkOutput("fetch_held_no_cen", fetch, 1'b1);
        applyStimulus(1'b1, 3'd6, 1'b0, 1'b0, 12'h000, 8'h00);
        checkOutput("after_fetch_col_we", {fetch, col_we}, 2'b01);

        $display("[TB] queue full, ignored plane and overflow");
        applyStimulus(1'b0, 3'd7, 1'b0, 1'b1, 12'h010, 8'h10);
        applyStimulus(1'b0, 3'd7, 1'b0, 1'b1, 12'h411, 8'h11);
        applyStimulus(1'b0, 3'd7, 1'b0, 1'b1, 12'h012, 8'h12);
        checkOutput("wait_after_3", cpu_wait, 1'b0);
        applyStimulus(1'b0, 3'd7, 1'b0, 1'b1, 12'h413, 8'h13);
        expectWrite(10'h010, 8'h10, 1'b0);
        expectWrite(10'h011, 8'h11, 1'b1);
        expectWrite(10'h012, 8'h12, 1'b0);
        expectWrite(10'h013, 8'h13, 1'b1);
        checkOutput("wait_after_4", {cpu_wait, ovf}, 2'b10);
        applyStimulus(1'b0, 3'd7, 1'b0, 1'b1, 12'h812, 8'hEE);
        checkOutput("ignored_plane_no_ovf", {cpu_wait, ovf}, 2'b10);
        applyStimulus(1'b0, 3'd7, 1'b0, 1'b1, 12'h014, 8'h14);
        checkOutput("fifth_dropped_ovf", {cpu_wait, ovf}, 2'b11);

        $display("[TB] blanking burst");
        // Queue is full here, so this push is dropped even though a pop happens.
        applyStimulus(1'b1, 3'd4, 1'b1, 1'b1, 12'h0AA, 8'hAA);
        checkOutput("burst_pop1_wait", {cpu_wait, fetch, code_we}, 3'b001);
        applyStimulus(1'b1, 3'd5, 1'b1, 1'b1, 12'h0BB, 8'hBB);
        expectWrite(10'h0BB, 8'hBB, 1'b0);
        checkOutput("burst_h5_no_fetch", {fetch, col_we}, 2'b01);
        applyStimulus(1'b1, 3'd6, 1'b1, 1'b0, 12'h000, 8'h00);
        checkOutput("burst_pop3", {fetch, code_we}, 2'b01);
        applyStimulus(1'b1, 3'd7, 1'b1, 1'b0, 12'h000, 8'h00);
        checkOutput("burst_pop4", {fetch, col_we}, 2'b01);
        applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, 12'h000, 8'h00);
        checkOutput("burst_pop5", {fetch, code_we}, 2'b01);
        applyStimulus(1'b1, 3'd1, 1'b1, 1'b0, 12'h000, 8'h00);
        checkOutput("burst_drained", {code_we, col_we, cpu_wait, ovf}, 4'b0001);

        $display("[TB] reset with entries queued");
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b1, 12'h031, 8'h31);
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b1, 12'h432, 8'h32);
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b1, 12'h033, 8'h33);
        rst = 1'b1;
        #1;
        checkOutput("midframe_reset", {ram_addr, ram_din, code_we, col_we, fetch, ovf, cpu_wait}, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 3'(i), 1'b1, 1'b0, 12'h000, 8'h00);
        end
        checkOutput("post_reset_quiet", {code_we, col_we, cpu_wait, ovf}, 4'b0000);

        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtpopeye_txt_arb.md
Name: jtpopeye_txt_arb

Overview:
- Schedules the text-layer tile RAMs (code plane and colour plane) between the CPU and the video scan.
- Each 8-pixel character cell has one reserved scan-fetch slot. The remaining 7 slots, and all slots during blanking, are available to CPU writes.
- CPU writes are queued in a small FIFO, so the CPU only waits when the queue is full.
- Sits between the CPU bus decoder and the text-layer RAM/shifter.

Parameters:
- FIFO_AW, 2, log2 of CPU write queue depth (default depth 4).
- FETCH_SLOT, 3'd5, H[2:0] value at which the scan read is issued.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- pxl_cen  in  1  pixel clock enable; all RAM-side outputs update only on clk edges with pxl_cen=1
- H  in  3  horizontal pixel counter low bits (slot index)
- blank  in  1  1 = horizontal or vertical blanking
- scan_addr  in  10  {V[7:3],H[7:3]} tile address for the current fetch
- cpu_we  in  1  CPU write request, sampled every clk edge
- cpu_addr  in  12  decoded CPU address; [11:10]=00 code plane, 01 colour plane, 1x ignored
- cpu_din  in  8  CPU write data
- cpu_wait  out  1  queue full; combinational from FIFO count
- ram_addr  out  10  address to both tile RAMs
- ram_din  out  8  write data to tile RAMs
- code_we  out  1  code-plane write enable
- col_we  out  1  colour-plane write enable
- fetch  out  1  1 for the pxl_cen period in which ram_addr holds a scan address
- ovf  out  1  sticky flag: a write was dropped

Behaviour:
- Reset (async, rst=1) forces these values:
  - FIFO empty, so cpu_wait=0.
  - ram_addr=0, ram_din=0.
  - code_we=0, col_we=0, fetch=0, ovf=0.
- Push, on any clk edge:
  - If cpu_we=1, cpu_addr[11]=0 and the FIFO is not full, push {cpu_addr[10:0], cpu_din}.
  - If cpu_we=1, cpu_addr[11]=0 and the FIFO is full, do not push and set ovf=1. ovf is cleared only by rst.
  - If cpu_addr[11]=1, the write is ignored: no push, no ovf change.
  - Fullness is evaluated before any pop on the same edge; a pop on the same edge does not create room for the push.
- Slot decision, on clk edge with pxl_cen=1, using the H value present at that edge:
  - Fetch slot (blank=0 and H==FETCH_SLOT):
    - ram_addr<=scan_addr, fetch<=1, code_we<=0, col_we<=0.
    - FIFO is not popped, even if full.
  - Write slot (any other slot, or any slot with blank=1) and FIFO non-empty:
    - Pop the head entry.
    - ram_addr<=entry[9:0], ram_din<=entry data.
    - code_we<=(entry[10]==0), col_we<=(entry[10]==1), fetch<=0.
  - Idle slot (write slot, FIFO empty):
    - code_we<=0, col_we<=0, fetch<=0.
    - ram_addr<=scan_addr, so the RAM read port idles on the scan address.
    - ram_din holds its value.
- Enable widths: code_we, col_we and fetch are each held for exactly one pxl_cen period.
- Ordering and latency:
  - Entries are written strictly in push order. Same-address writes are never merged.
  - A write pushed at edge t is issued at the first pxl_cen edge after t that is a write slot and finds it at the FIFO head.
  - The earliest case is 1 pxl_cen edge after the push.
- Throughput:
  - Active video: at most 7 writes per 8 pixels.
  - Blanking: 1 write per pxl_cen.
- Pointers: read and write pointers are FIFO_AW+1 bits and wrap modulo 2^(FIFO_AW+1).
  - full = MSBs differ and remaining bits are equal.
  - empty = pointers equal.
- Simultaneous push and pop on a non-full, non-empty FIFO: both take effect and the count is unchanged.
- Simultaneous push and pop on an empty FIFO: the pop sees empty (idle slot), and the entry is issued at the next write slot.
- Reset mid-operation: queued entries are discarded; no partial write is issued.

Test Plan:
- Reset and idle: assert rst mid-frame with 3 entries queued -> all outputs 0, cpu_wait=0, and no code_we/col_we pulses appear after release.
- Single write, active video: push addr=12'h045, din=8'hA7 at H=2 -> at the next pxl_cen edge, ram_addr=10'h045, ram_din=A7, code_we=1 for one pxl_cen; col_we=0.
- Fetch collision: push a colour write (addr=12'h7FF) landing just before the H=5 edge, blank=0 -> at the H=5 edge fetch=1 and ram_addr=scan_addr; the write issues at the H=6 edge with col_we=1 and ram_addr=10'h3FF.
- Queue full: pushes of 5 writes on consecutive clk edges with no pxl_cen -> cpu_wait=1 after the 4th; the 5th is dropped and ovf=1; the 4 queued entries issue in order.
- Blanking burst: 4 queued writes with blank=1 across H=4..7 -> 4 writes on 4 consecutive pxl_cen edges, fetch stays 0.
- Ignored plane: cpu_we with cpu_addr[11:10]=2'b10 -> no push, no write issued, ovf unchanged.
